// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (processor load/store port C, DMA port D),
// the shared data memory, and the dmem_arbiter that multiplexes them.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  // Port C: processor load/store path
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_ack;
  logic [DATA_W-1:0] c_rdata;
  logic              c_stall;

  // Port D: DMA / loader engine
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  // Single-port data memory
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_memwrite;
  logic              mem_memread;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_readdata,
    output c_ack, c_rdata, c_stall,
    output d_ack, d_rdata,
    output mem_address, mem_writedata, mem_memwrite, mem_memread
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output mem_readdata,
    input  c_ack, c_rdata, c_stall,
    input  d_ack, d_rdata,
    input  mem_address, mem_writedata, mem_memwrite, mem_memread
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the processor
// (port C) and a DMA engine (port D); one registered grant per cycle, zero-wait memory.
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus,
  input  logic          cnt_clr,
  output logic [15:0]   conflict_cnt
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_C    = 2'b01,
    GNT_D    = 2'b10
  } gnt_state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  gnt_state_t        gnt_q, gnt_d;
  logic              last_id_q, last_id_d;
  logic [15:0]       conflict_cnt_q, conflict_cnt_d;

  logic              c_ack, d_ack;
  logic              c_elig, d_elig;
  logic              contention;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_memwrite, mem_memread;

  // The port acked this cycle sits out the next edge so its still-high req is not re-served.
  always_comb begin
    c_ack  = (gnt_q == GNT_C);
    d_ack  = (gnt_q == GNT_D);
    c_elig = bus.c_req & ~c_ack;
    d_elig = bus.d_req & ~d_ack;
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_d     = GNT_NONE;
    last_id_d = last_id_q;
    if (c_elig && d_elig) begin
      if (last_id_q == PORT_D) begin
        gnt_d     = GNT_C;
        last_id_d = PORT_C;
      end else begin
        gnt_d     = GNT_D;
        last_id_d = PORT_D;
      end
    end else if (c_elig) begin
      gnt_d     = GNT_C;
      last_id_d = PORT_C;
    end else if (d_elig) begin
      gnt_d     = GNT_D;
      last_id_d = PORT_D;
    end
  end

  // Contention: both want the memory but neither is served, or one is served while the other waits.
  always_comb begin
    contention = (bus.c_req & bus.d_req & ~(c_ack | d_ack))
               | (c_ack & bus.d_req)
               | (d_ack & bus.c_req);

    conflict_cnt_d = conflict_cnt_q;
    if (cnt_clr) begin
      conflict_cnt_d = '0;
    end else if (contention && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // Memory side is driven straight from the granted port so memwrite is stable for the whole cycle.
  always_comb begin
    mem_address   = '0;
    mem_writedata = '0;
    mem_memwrite  = 1'b0;
    mem_memread   = 1'b0;
    unique case (gnt_q)
      GNT_C: begin
        mem_address   = bus.c_addr;
        mem_writedata = bus.c_wdata;
        mem_memwrite  = bus.c_we;
        mem_memread   = ~bus.c_we;
      end
      GNT_D: begin
        mem_address   = bus.d_addr;
        mem_writedata = bus.d_wdata;
        mem_memwrite  = bus.d_we;
        mem_memread   = ~bus.d_we;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q          <= GNT_NONE;
      last_id_q      <= PORT_D;
      conflict_cnt_q <= '0;
    end else begin
      gnt_q          <= gnt_d;
      last_id_q      <= last_id_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign bus.c_ack         = c_ack;
  assign bus.d_ack         = d_ack;
  assign bus.c_stall       = bus.c_req & ~c_ack;
  assign bus.c_rdata       = (c_ack && !bus.c_we) ? bus.mem_readdata : '0;
  assign bus.d_rdata       = (d_ack && !bus.d_we) ? bus.mem_readdata : '0;
  assign bus.mem_address   = mem_address;
  assign bus.mem_writedata = mem_writedata;
  assign bus.mem_memwrite  = mem_memwrite;
  assign bus.mem_memread   = mem_memread;
  assign conflict_cnt      = conflict_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the round-robin grant rules and memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [15:0] conflict_cnt;
  int          n_tests = 0;
  int          n_fail = 0;

  dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .cnt_clr      (cnt_clr),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  // Zero-wait memory: combinational read, write on the falling edge.
  logic [15:0] mem [0:255];
  always @(negedge clk) begin
    if (bus.mem_memwrite) mem[bus.mem_address[7:0]] = bus.mem_writedata;
  end
  assign bus.mem_readdata = mem[bus.mem_address[7:0]];

  // Requester contract: a req may only fall once its ack cycle has completed.
  logic c_req_s = 1'b0, c_ack_s = 1'b0, d_req_s = 1'b0, d_ack_s = 1'b0, reset_s = 1'b0;
  always @(negedge clk) begin
    if (reset && reset_s) begin
      assert (!(c_req_s && !c_ack_s && !bus.c_req)) else $error("c_req dropped before its ack");
      assert (!(d_req_s && !d_ack_s && !bus.d_req)) else $error("d_req dropped before its ack");
    end
    c_req_s <= bus.c_req;
    c_ack_s <= bus.c_ack;
    d_req_s <= bus.d_req;
    d_ack_s <= bus.d_ack;
    reset_s <= reset;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 16'h0020; bus.c_wdata = 16'h5555;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.c_ack !== 1'b0) begin n_fail++; $display("FAIL reset_c_ack: got %b want 0", bus.c_ack); end
    n_tests++;
    if (bus.mem_memwrite !== 1'b0) begin n_fail++; $display("FAIL reset_memwrite: got %b want 0", bus.mem_memwrite); end
    n_tests++;
    if (conflict_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt: got %h want 0000", conflict_cnt); end
    n_tests++;
    if (bus.c_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b want 1", bus.c_stall); end
    reset = 1'b1;
    step();
    n_tests++;
    if ({bus.c_ack, bus.mem_memwrite, bus.mem_address} !== {1'b1, 1'b1, 16'h0020}) begin
      n_fail++; $display("FAIL reset_first_grant: got ack/we/addr %b/%b/%h want 1/1/0020",
                         bus.c_ack, bus.mem_memwrite, bus.mem_address);
    end
    step();
    bus.c_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem[8'h20] !== 16'h5555) begin n_fail++; $display("FAIL reset_write_data: got %h want 5555", mem[8'h20]); end
    step();
  endtask

  task automatic test_single_read();
    mem[7] = 16'h1234;
    bus.c_we = 1'b0; bus.c_addr = 16'h0007; bus.c_req = 1'b1;
    step();
    n_tests++;
    if ({bus.c_ack, bus.c_rdata, bus.mem_memread} !== {1'b1, 16'h1234, 1'b1}) begin
      n_fail++; $display("FAIL read_first: got ack/rdata/rd %b/%h/%b want 1/1234/1", bus.c_ack, bus.c_rdata, bus.mem_memread);
    end
    step();
    n_tests++;
    if ({bus.c_ack, bus.c_stall, bus.c_rdata} !== {1'b0, 1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL read_mask: got ack/stall/rdata %b/%b/%h want 0/1/0000", bus.c_ack, bus.c_stall, bus.c_rdata);
    end
    step();
    n_tests++;
    if (bus.c_ack !== 1'b1) begin n_fail++; $display("FAIL read_second: got %b want 1", bus.c_ack); end
    step();
    bus.c_req = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    reset = 1'b0;
    bus.c_we = 1'b0; bus.c_addr = 16'h0007; bus.c_req = 1'b1;
    bus.d_we = 1'b1; bus.d_addr = 16'h0010; bus.d_wdata = 16'hBEEF; bus.d_req = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_tests++;
      if ({bus.c_ack, bus.d_ack} !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rr_order_%0d: got c/d ack %b%b want %s", k, bus.c_ack, bus.d_ack, (k % 2 == 1) ? "10" : "01");
      end
      n_tests++;
      if (conflict_cnt !== 16'(k)) begin n_fail++; $display("FAIL rr_cnt_%0d: got %h want %h", k, conflict_cnt, 16'(k)); end
      if (k == 1) begin
        n_tests++;
        if (bus.c_rdata !== 16'h1234) begin n_fail++; $display("FAIL rr_rdata: got %h want 1234", bus.c_rdata); end
      end
      if (k == 3) begin
        n_tests++;
        if (mem[16] !== 16'hBEEF) begin n_fail++; $display("FAIL rr_dma_write: got %h want beef", mem[16]); end
      end
    end
    bus.c_req = 1'b0;
    step();
    n_tests++;
    if ({bus.c_ack, bus.d_ack} !== 2'b00) begin n_fail++; $display("FAIL rr_idle: got %b%b want 00", bus.c_ack, bus.d_ack); end
    bus.d_req = 1'b0;
    step();
  endtask

  task automatic test_stall();
    bus.d_we = 1'b1; bus.d_addr = 16'h0011; bus.d_wdata = 16'hA5A5; bus.d_req = 1'b1;
    bus.c_we = 1'b0; bus.c_addr = 16'h0007;
    step();
    bus.c_req = 1'b1;
    #1;
    n_tests++;
    if ({bus.d_ack, bus.c_ack, bus.c_stall} !== 3'b101) begin
      n_fail++; $display("FAIL stall_raise: got d_ack/c_ack/stall %b%b%b want 101", bus.d_ack, bus.c_ack, bus.c_stall);
    end
    step();
    n_tests++;
    if ({bus.c_ack, bus.d_ack, bus.c_stall, bus.c_rdata} !== {3'b100, 16'h1234}) begin
      n_fail++; $display("FAIL stall_release: got c/d/stall %b%b%b rdata %h want 100 1234",
                         bus.c_ack, bus.d_ack, bus.c_stall, bus.c_rdata);
    end
    step();
    n_tests++;
    if ({bus.c_ack, bus.d_ack} !== 2'b01) begin n_fail++; $display("FAIL stall_dma_again: got %b%b want 01", bus.c_ack, bus.d_ack); end
    bus.c_req = 1'b0;
    step();
    bus.d_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_grant();
    bus.c_we = 1'b0; bus.c_addr = 16'h0007; bus.c_req = 1'b1;
    bus.d_we = 1'b1; bus.d_addr = 16'h0012; bus.d_wdata = 16'h0F0F; bus.d_req = 1'b1;
    step();
    step();
    n_tests++;
    if (bus.d_ack !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got d_ack %b want 1", bus.d_ack); end
    #1 reset = 1'b0;
    #1;
    n_tests++;
    if ({bus.d_ack, bus.c_ack, bus.mem_memwrite, bus.c_stall, conflict_cnt} !== {4'b0001, 16'h0000}) begin
      n_fail++; $display("FAIL midrst_abort: got d/c/we/stall %b%b%b%b cnt %h want 0001 0000",
                         bus.d_ack, bus.c_ack, bus.mem_memwrite, bus.c_stall, conflict_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    n_tests++;
    if ({bus.c_ack, bus.d_ack} !== 2'b10) begin n_fail++; $display("FAIL midrst_first: got %b%b want 10", bus.c_ack, bus.d_ack); end
    step();
    bus.c_req = 1'b0;
    step();
    bus.d_req = 1'b0;
    step();
  endtask

  task automatic test_counter();
    @(negedge clk);
    force dut.conflict_cnt_q = 16'hFFFE;
    #1 release dut.conflict_cnt_q;
    #1;
    n_tests++;
    if (conflict_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL cnt_preload: got %h want fffe", conflict_cnt); end
    bus.c_we = 1'b0; bus.c_addr = 16'h0007; bus.c_req = 1'b1;
    bus.d_we = 1'b0; bus.d_addr = 16'h0010; bus.d_req = 1'b1;
    step();
    n_tests++;
    if (conflict_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_reach_max: got %h want ffff", conflict_cnt); end
    step();
    n_tests++;
    if (conflict_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_saturate: got %h want ffff", conflict_cnt); end
    cnt_clr = 1'b1;
    step();
    n_tests++;
    if (conflict_cnt !== 16'h0000) begin n_fail++; $display("FAIL cnt_clear_at_max: got %h want 0000", conflict_cnt); end
    cnt_clr = 1'b0;
    bus.d_req = 1'b0;
    step();
    n_tests++;
    if (conflict_cnt !== 16'h0000) begin n_fail++; $display("FAIL cnt_hold_zero: got %h want 0000", conflict_cnt); end
    bus.c_req = 1'b0;
    step();
  endtask

  // Model: each edge, a requesting port that was not just served is a candidate;
  // a tie goes to whichever port did not win last. Memory contents tracked in ref_mem.
  task automatic test_random(input int n_cycles);
    logic [15:0] ref_mem [256];
    logic        m_c_ack, m_d_ack, m_last_d, prev_c, prev_d, c_want, d_want;
    logic [15:0] m_cnt;
    logic [15:0] e_addr, e_wdata, e_c_rdata, e_d_rdata;
    logic        e_we, e_rd;
    int          n_mem_bad;

    bus.c_req = 1'b0; bus.d_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    m_c_ack = 1'b0; m_d_ack = 1'b0; m_last_d = 1'b1; m_cnt = 16'h0000;

    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      c_want = bus.c_req && !m_c_ack;
      d_want = bus.d_req && !m_d_ack;
      if (bus.c_req && bus.d_req && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      prev_c = m_c_ack;
      prev_d = m_d_ack;
      m_c_ack = c_want && (!d_want || m_last_d);
      m_d_ack = d_want && !m_c_ack;
      if (m_c_ack) m_last_d = 1'b0;
      if (m_d_ack) m_last_d = 1'b1;

      e_addr = 16'h0; e_wdata = 16'h0; e_we = 1'b0; e_rd = 1'b0;
      if (m_c_ack) begin e_addr = bus.c_addr; e_wdata = bus.c_wdata; e_we = bus.c_we; e_rd = !bus.c_we; end
      if (m_d_ack) begin e_addr = bus.d_addr; e_wdata = bus.d_wdata; e_we = bus.d_we; e_rd = !bus.d_we; end
      e_c_rdata = (m_c_ack && !bus.c_we) ? ref_mem[bus.c_addr[7:0]] : 16'h0;
      e_d_rdata = (m_d_ack && !bus.d_we) ? ref_mem[bus.d_addr[7:0]] : 16'h0;

      step();

      n_tests++;
      if ({bus.c_ack, bus.d_ack, bus.c_stall, bus.mem_memwrite, bus.mem_memread, conflict_cnt} !==
          {m_c_ack, m_d_ack, bus.c_req && !m_c_ack, e_we, e_rd, m_cnt}) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc %0d: got c/d/stall/we/rd %b%b%b%b%b cnt %h want %b%b%b%b%b cnt %h", cyc,
                 bus.c_ack, bus.d_ack, bus.c_stall, bus.mem_memwrite, bus.mem_memread, conflict_cnt,
                 m_c_ack, m_d_ack, bus.c_req && !m_c_ack, e_we, e_rd, m_cnt);
      end
      n_tests++;
      if ({bus.mem_address, bus.mem_writedata, bus.c_rdata, bus.d_rdata} !== {e_addr, e_wdata, e_c_rdata, e_d_rdata}) begin
        n_fail++;
        $display("FAIL rand_data cyc %0d: got addr/wd/crd/drd %h/%h/%h/%h want %h/%h/%h/%h", cyc,
                 bus.mem_address, bus.mem_writedata, bus.c_rdata, bus.d_rdata, e_addr, e_wdata, e_c_rdata, e_d_rdata);
      end
      if (e_we) ref_mem[e_addr[7:0]] = e_wdata;

      // A port may change only when idle or right after its ack cycle has ended.
      if (prev_c || !bus.c_req) begin
        bus.c_req   = ($urandom_range(99) < 60);
        bus.c_we    = 1'($urandom_range(1));
        bus.c_addr  = 16'($urandom_range(255));
        bus.c_wdata = 16'($urandom);
      end
      if (prev_d || !bus.d_req) begin
        bus.d_req   = ($urandom_range(99) < 60);
        bus.d_we    = 1'($urandom_range(1));
        bus.d_addr  = 16'($urandom_range(255));
        bus.d_wdata = 16'($urandom);
      end
    end

    // Drain: let outstanding requests finish, then idle both ports.
    for (int k = 0; k < 6; k++) begin
      prev_c = bus.c_ack; prev_d = bus.d_ack;
      step();
      if (prev_c || (bus.c_req && !bus.c_ack && !bus.c_stall)) bus.c_req = 1'b0;
      if (prev_d) bus.d_req = 1'b0;
      if (bus.c_ack && bus.c_we) ref_mem[bus.c_addr[7:0]] = bus.c_wdata;
      if (bus.d_ack && bus.d_we) ref_mem[bus.d_addr[7:0]] = bus.d_wdata;
    end
    @(negedge clk);
    n_mem_bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n_mem_bad++;
    n_tests++;
    if (n_mem_bad != 0) begin n_fail++; $display("FAIL rand_mem_image: got %0d differing words want 0", n_mem_bad); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_stall();
    test_reset_mid_grant();
    test_counter();
    test_random(600);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port 16-bit data memory between the processor's load/store path (port C) and a DMA/loader engine (port D). It registers one grant per cycle using round-robin priority and drives the memory's address, write-data, memwrite and memread inputs from the granted port. It also returns read data and a one-cycle acknowledge, gives the processor a stall signal for freezing the PC, and counts contention cycles.

## Interface
- ADDR_W, 16, address width of both ports and memory
- DATA_W, 16, data width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- c_req  in  1  processor access request; held until c_ack
- c_we  in  1  processor write (1) / read (0); stable while c_req
- c_addr  in  ADDR_W  processor address; stable while c_req
- c_wdata  in  DATA_W  processor write data; stable while c_req
- c_ack  out  1  processor access performed this cycle
- c_rdata  out  DATA_W  read data, valid when c_ack & ~c_we
- c_stall  out  1  c_req & ~c_ack (freezes program counter)
- d_req, d_we, d_addr, d_wdata  in  1/1/ADDR_W/DATA_W  DMA equivalents
- d_ack, d_rdata  out  1/DATA_W  DMA equivalents
- mem_address  out  ADDR_W  to data memory
- mem_writedata  out  DATA_W  to data memory
- mem_memwrite  out  1  to data memory
- mem_memread  out  1  to data memory
- mem_readdata  in  DATA_W  combinational read data from memory
- cnt_clr  in  1  synchronous clear of contention counter
- conflict_cnt  out  16  saturating count of cycles with both c_req and d_req high and no grant to one of them

## Operation
- State: gnt_valid (1b), gnt_id (1b, 0=C, 1=D), last_id (1b), conflict_cnt (16b).
- Arbitration at every rising edge:
  - Eligible port = req high and not the port acked in the current cycle. The just-acked port is masked for one edge, so its still-high req is not re-served.
  - None eligible: gnt_valid<=0.
  - One eligible: grant it.
  - Both eligible: grant ~last_id (round-robin).
  - On grant: gnt_valid<=1, gnt_id<=winner, last_id<=winner.
- Grant cycle (gnt_valid=1): mem_* are driven combinationally from the granted port's inputs.
  - mem_memwrite=we, mem_memread=~we.
  - Granted ack=1; other ack=0.
  - Both rdata outputs = mem_readdata when that port is acked and reading, else 0.
- No grant: mem_memwrite=0, mem_memread=0, mem_address=0, mem_writedata=0.
- Requester contract:
  - Hold req/we/addr/wdata through the ack cycle.
  - Deassert req or change it to the next transaction only after the ack edge.
  - Dropping req before ack is illegal; the bench asserts on it.
- conflict_cnt:
  - Increments on each edge where c_req & d_req & ~(c_ack|d_ack), and on each edge where one port is acked while the other requests.
  - Saturates at 16'hFFFF. cnt_clr has priority over increment.

## Timing
- Reset (reset=0, async): gnt_valid=0, last_id=1 (C wins first tie), conflict_cnt=0.
  - All outputs 0 during reset, except c_stall=c_req.
- Latency: req rising before edge N → ack in cycle N (one cycle after request assertion, zero-wait memory).
- Same-port throughput: one access per 2 cycles (mask edge). Alternating ports: one access per cycle.
- Both requesting continuously: grants alternate C, D, C, D…; no port waits more than 2 edges.
- Writes: mem_memwrite is stable for the whole grant cycle, satisfying the memory's falling-edge write.
- Reset asserted mid-grant: grant aborts immediately, no ack. The memory write may or may not occur.
  - After release, the first edge arbitrates afresh with last_id=1.
- Simultaneous cnt_clr and saturation: counter reads 0 next cycle.

## Test plan
- Reset: hold reset=0 with c_req=1 → c_ack=0, mem_memwrite=0, conflict_cnt=0, c_stall=1. Release reset → c_ack=1 at the first edge after release.
- Single CPU read: c_req=1, c_we=0, c_addr=16'h0007, memory[7]=16'h1234 → c_ack=1 one cycle later, c_rdata=16'h1234. Next cycle c_ack=0 with c_req still high (mask). Acked again the following cycle.
- Tie and round-robin: c_req and d_req both high from reset, DMA writing 16'hBEEF to 16'h0010 → ack order C, D, C, D. memory[16]=16'hBEEF after the first d_ack cycle. conflict_cnt increments every cycle.
- Stall: d_req held continuously, c_req raised while D is granted → c_stall=1 for that cycle. c_ack arrives on the next edge.
- Reset mid-grant: assert reset during a d_ack cycle → d_ack drops asynchronously. After release, with both requesting, C is granted first.
- Counter: force 16'hFFFE, two contention cycles → 16'hFFFF and holds. Pulse cnt_clr → 0.
